blk_addr_alloc_arb: RTL and testbench
=====================================

// Module: blk_addr_alloc_arb
// PURPOSE
// - Shared free-block allocator for the multi-port cache write side.
// - Owns the free list of SRAM block addresses and arbitrates single-cycle address requests from NUM_PORT input_ctrl instances, round-robin.
// - Returns one block address per grant and accepts released addresses back from the read/output side.
// PARAMETERS
// - NUM_PORT        16    number of requesting input_ctrl ports
// - NUM_BLK         512   number of SRAM blocks managed (>=2)
// - BLK_ADDR_WIDTH  9     block address width, = $clog2(NUM_BLK)
// - CNT_WIDTH       10    free-count width, = $clog2(NUM_BLK+1)
// PORTS
// - i_clk           in   1               single clock, all logic rising-edge
// - i_rst           in   1               synchronous reset, active-high
// - i_addr_req      in   NUM_PORT        per-port 1-cycle request pulse (input_ctrl o_addr_req)
// - o_blk_addr_vld  out  NUM_PORT        one-hot grant; addr valid for that port this cycle
// - o_blk_addr      out  BLK_ADDR_WIDTH  granted block address (shared bus)
// - i_rel_vld       in   1               release strobe
// - i_rel_addr      in   BLK_ADDR_WIDTH  address returned to free list
// - o_free_cnt      out  CNT_WIDTH       addresses currently in free list
// - o_init_done     out  1               free list initialised, requests serviceable
// - o_err           out  1               sticky: request overrun or release while full
// BEHAVIOUR
// - Reset values: o_blk_addr_vld=0, o_blk_addr=0, o_free_cnt=0, o_init_done=0, o_err=0; pending=0; rr pointer=NUM_PORT-1; head=tail=0.
// - FSM: INIT -> RUN. Reset (any time, incl. mid-grant) returns to INIT and discards all pending requests and list contents.
// - INIT: write address k to free-list slot k, one per cycle, k=0..NUM_BLK-1; o_free_cnt increments each cycle; after slot NUM_BLK-1, o_init_done=1 and state=RUN (NUM_BLK cycles).
// - Requests in INIT: latched into pending, not granted until RUN. Releases in INIT: ignored, o_err set.
// - Pending: pend[k] is set on i_addr_req[k] and cleared on grant to k. A pulse while pend[k]=1 and k is not granted that cycle is dropped and sets o_err. A pulse in the same cycle as a grant to k re-sets pend[k].
// - Arbitration (RUN, o_free_cnt!=0): pick the first set pend bit searching upward from rr+1 modulo NUM_PORT; rr<=winner. Pop head: o_blk_addr<=list[head], o_blk_addr_vld<=onehot(winner), both registered.
// - Latency: request pulse at edge t -> pend at t+1 -> grant output valid for one cycle after edge t+2 (minimum).
// - At most one grant per cycle; o_blk_addr_vld is 0 in non-grant cycles; o_blk_addr holds its last value.
// - Empty list (o_free_cnt=0): no grant, pend held. No same-cycle release->grant bypass; a released address is grantable from the next cycle.
// - Release (RUN): list[tail]<=i_rel_addr, tail++. If o_free_cnt==NUM_BLK, the release is ignored and o_err is set.
// - Simultaneous pop and push: o_free_cnt unchanged, both pointers advance.
// - Pointers wrap NUM_BLK-1 -> 0; modulo arithmetic is required when NUM_BLK is not a power of 2.
// - No duplicate-address check on release; the caller guarantees uniqueness.
// - o_err clears only on reset.
// CONFIGURATION
// - Macro ALLOC_STALL_CNT_EN:
//   - Defined: adds port o_stall_cnt [31:0]. It increments every RUN cycle with |pend=1 and o_free_cnt=0, saturates at 32'hFFFF_FFFF, and resets to 0.
//   - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING (NUM_PORT=4, NUM_BLK=8 unless noted)
// - Init: release reset, no stimulus -> o_init_done rises exactly 8 cycles after reset deassert, o_free_cnt=8; the first 8 grants return addr 0..7 in order.
// - Round-robin: pulse i_addr_req=4'b1111 once after init -> grants to ports 0,1,2,3 on 4 consecutive cycles with addr 0,1,2,3; o_free_cnt=4.
// - Empty: 9 requests across ports with no release -> 8 grants, port of 9th holds pend; i_rel_addr=5 -> that port gets addr 5 two cycles after the release; o_free_cnt=0.
// - Overrun: pulse port 2 twice while the list is empty -> o_err=1, one grant only after a release.
// - Full release: release addr 3 at o_free_cnt=8 -> o_err=1, o_free_cnt stays 8.
// - Reset mid-op: assert i_rst during a grant cycle -> next cycle all outputs at reset values; re-init reproduces addr 0..7.
// - With ALLOC_STALL_CNT_EN: 1 pending request and an empty list for 10 cycles -> o_stall_cnt=10.

Source files
------------

// File: rtl/blk_addr_alloc_arb.sv
// blk_addr_alloc_arb: shared free-block allocator for the multi-port cache write side.
//
// Owns a circular free list of SRAM block addresses. After reset the list is filled
// with addresses 0..NUM_BLK-1, one per cycle (INIT). In RUN, per-port request pulses
// are latched as pending bits. One pending port per cycle is granted round-robin, and
// the grant pops one address off the head. Released addresses are pushed at the tail.
//
// Ports:
//   i_clk, i_rst     clock and synchronous active-high reset
//   i_addr_req       per-port 1-cycle request pulse
//   o_blk_addr_vld   one-hot registered grant
//   o_blk_addr       registered granted address; holds its last value between grants
//   i_rel_vld        release strobe
//   i_rel_addr       address returned to the free list
//   o_free_cnt       number of addresses currently in the free list
//   o_init_done      free list initialised
//   o_err            sticky error: request overrun, or release during INIT or while full
//   o_stall_cnt      (ALLOC_STALL_CNT_EN only) saturating count of RUN cycles with
//                    requests pending and an empty list
//
// Optional feature macro: ALLOC_STALL_CNT_EN.
module blk_addr_alloc_arb #(
  parameter int unsigned NUM_PORT       = 16,
  parameter int unsigned NUM_BLK        = 512,
  parameter int unsigned BLK_ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH      = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_PORT-1:0]       i_addr_req,
  output logic [NUM_PORT-1:0]       o_blk_addr_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
  input  logic                      i_rel_vld,
  input  logic [BLK_ADDR_WIDTH-1:0] i_rel_addr,
  output logic [CNT_WIDTH-1:0]      o_free_cnt,
  output logic                      o_init_done,
  output logic                      o_err
`ifdef ALLOC_STALL_CNT_EN
  ,
  output logic [31:0]               o_stall_cnt
`endif
);

  localparam int unsigned PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int unsigned AW = BLK_ADDR_WIDTH;
  localparam int unsigned CW = CNT_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_PORT-1:0] pend_q, pend_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [NUM_PORT-1:0] vld_q, vld_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                err_q, err_d;
  logic                init_done_q, init_done_d;

  logic [AW-1:0]       list_q [NUM_BLK];
  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       wr_data;

  logic                found;
  logic [PW-1:0]       winner;
  logic                pop;
  logic                push;
  logic [NUM_PORT-1:0] grant;

  // Explicit compare-and-wrap so non-power-of-2 list sizes work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(NUM_BLK - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search: first pending port strictly after the last winner.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 1; i <= NUM_PORT; i++) begin
      idx = (int'(rr_q) + i) % NUM_PORT;
      if (!found && pend_q[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    vld_d       = '0;
    grant       = '0;
    wr_en       = 1'b0;
    wr_idx      = tail_q;
    wr_data     = i_rel_addr;
    push        = 1'b0;

    pop = (state_q == StRun) && found && (cnt_q != '0);
    if (pop) begin
      grant[winner] = 1'b1;
      vld_d         = grant;
      addr_d        = list_q[head_q];
      head_d        = ptr_inc(head_q);
      rr_d          = winner;
    end

    // A pulse coinciding with its own grant re-arms the pending bit.
    pend_d = (pend_q & ~grant) | i_addr_req;
    if (|(i_addr_req & pend_q & ~grant)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StInit: begin
        // cnt_q doubles as the fill index: slot k gets address k.
        wr_en   = 1'b1;
        wr_idx  = cnt_q[AW-1:0];
        wr_data = cnt_q[AW-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NUM_BLK - 1)) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
        if (i_rel_vld) begin
          err_d = 1'b1;
        end
      end
      StRun: begin
        push = i_rel_vld && (cnt_q != CW'(NUM_BLK));
        if (i_rel_vld && !push) begin
          err_d = 1'b1;
        end
        if (push) begin
          wr_en  = 1'b1;
          tail_d = ptr_inc(tail_q);
        end
        if (push && !pop) begin
          cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StInit;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      rr_q        <= PW'(NUM_PORT - 1);
      vld_q       <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      vld_q       <= vld_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  // List storage needs no reset; INIT rewrites every slot before use.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      list_q[wr_idx] <= wr_data;
    end
  end

`ifdef ALLOC_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && (|pend_q) && (cnt_q == '0) && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

  assign o_blk_addr_vld = vld_q;
  assign o_blk_addr     = addr_q;
  assign o_free_cnt     = cnt_q;
  assign o_init_done    = init_done_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_blk_addr_alloc_arb.sv
// Directed testbench for blk_addr_alloc_arb with NUM_PORT=4, NUM_BLK=8.
module tb_blk_addr_alloc_arb;

  localparam int unsigned NP = 4;
  localparam int unsigned NB = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] addr_req;
  logic [NP-1:0] blk_addr_vld;
  logic [AW-1:0] blk_addr;
  logic          rel_vld;
  logic [AW-1:0] rel_addr;
  logic [CW-1:0] free_cnt;
  logic          init_done;
  logic          err;
`ifdef ALLOC_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  blk_addr_alloc_arb #(
    .NUM_PORT      (NP),
    .NUM_BLK       (NB),
    .BLK_ADDR_WIDTH(AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_addr_req    (addr_req),
    .o_blk_addr_vld(blk_addr_vld),
    .o_blk_addr    (blk_addr),
    .i_rel_vld     (rel_vld),
    .i_rel_addr    (rel_addr),
    .o_free_cnt    (free_cnt),
    .o_init_done   (init_done),
    .o_err         (err)
`ifdef ALLOC_STALL_CNT_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".vld"}, 32'(blk_addr_vld), 32'd0);
    check({tag, ".addr"}, 32'(blk_addr), 32'd0);
    check({tag, ".cnt"}, 32'(free_cnt), 32'd0);
    check({tag, ".init_done"}, 32'(init_done), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
  endtask

  // Reset, then wait out the 8-cycle fill and check when init_done rises.
  task automatic reset_and_init(input string tag);
    rst      = 1'b1;
    addr_req = '0;
    rel_vld  = 1'b0;
    rel_addr = '0;
    step();
    step();
    check_reset_outputs({tag, ".rst"});
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check({tag, ".init_done_at7"}, 32'(init_done), 32'd0);
    check({tag, ".cnt_at7"}, 32'(free_cnt), 32'd7);
    step();
    check({tag, ".init_done_at8"}, 32'(init_done), 32'd1);
    check({tag, ".cnt_at8"}, 32'(free_cnt), 32'd8);
  endtask

  // Pulse all four ports once; expect grants 0..3 on consecutive cycles.
  task automatic run_grants(input string tag, input int base, input int exp_cnt);
    addr_req = 4'b1111;
    step();
    addr_req = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("%s.vld%0d", tag, i), 32'(blk_addr_vld), 32'(1 << i));
      check($sformatf("%s.addr%0d", tag, i), 32'(blk_addr), 32'(base + i));
    end
    step();
    check({tag, ".vld_idle"}, 32'(blk_addr_vld), 32'd0);
    check({tag, ".addr_hold"}, 32'(blk_addr), 32'(base + 3));
    check({tag, ".cnt"}, 32'(free_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst      = 1'b1;
    addr_req = '0;
    rel_vld  = 1'b0;
    rel_addr = '0;

    // Init timing, then round-robin drain of all 8 addresses in order.
    reset_and_init("init");
    run_grants("rr0", 0, 4);
    run_grants("rr1", 4, 0);

    // Empty list: 9th request waits in pend until an address is released.
    addr_req = 4'b0010;
    step();
    addr_req = '0;
    step();
    step();
    check("empty.no_grant", 32'(blk_addr_vld), 32'd0);
    check("empty.cnt", 32'(free_cnt), 32'd0);
    rel_vld  = 1'b1;
    rel_addr = 3'd5;
    step();
    rel_vld = 1'b0;
    check("empty.no_bypass", 32'(blk_addr_vld), 32'd0);
    check("empty.cnt_after_rel", 32'(free_cnt), 32'd1);
    step();
    check("empty.grant_vld", 32'(blk_addr_vld), 32'b0010);
    check("empty.grant_addr", 32'(blk_addr), 32'd5);
    check("empty.cnt_after_grant", 32'(free_cnt), 32'd0);
    check("empty.err", 32'(err), 32'd0);

    // Overrun: second pulse on port 2 while still pending sets err; one grant only.
    addr_req = 4'b0100;
    step();
    addr_req = '0;
    step();
    addr_req = 4'b0100;
    step();
    addr_req = '0;
    check("ovr.err", 32'(err), 32'd1);
    step();
    check("ovr.no_grant", 32'(blk_addr_vld), 32'd0);
    rel_vld  = 1'b1;
    rel_addr = 3'd2;
    step();
    rel_vld = 1'b0;
    step();
    check("ovr.grant_vld", 32'(blk_addr_vld), 32'b0100);
    check("ovr.grant_addr", 32'(blk_addr), 32'd2);
    step();
    check("ovr.single_grant", 32'(blk_addr_vld), 32'd0);
    check("ovr.cnt", 32'(free_cnt), 32'd0);

    // Release while full is dropped and flagged.
    reset_and_init("full");
    check("full.err_before", 32'(err), 32'd0);
    rel_vld  = 1'b1;
    rel_addr = 3'd3;
    step();
    rel_vld = 1'b0;
    check("full.err", 32'(err), 32'd1);
    check("full.cnt", 32'(free_cnt), 32'd8);

    // Reset asserted during a grant cycle, then re-init reproduces 0..7.
    reset_and_init("mid");
    addr_req = 4'b0001;
    step();
    addr_req = '0;
    step();
    check("mid.grant_vld", 32'(blk_addr_vld), 32'b0001);
    rst = 1'b1;
    step();
    check_reset_outputs("mid.after_rst");
    reset_and_init("reinit");
    run_grants("re0", 0, 4);
    run_grants("re1", 4, 0);

`ifdef ALLOC_STALL_CNT_EN
    addr_req = 4'b0001;
    step();
    addr_req = '0;
    for (int i = 0; i < 10; i++) step();
    check("stall.cnt", stall_cnt, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
